// File: rtl/serial_rx_checker.sv
// Serial receive checker: hunts for SYNC_WORD, deserializes MSB-first bytes and
// checks them against an incrementing pattern. Define SERIAL_RX_ERR_CNT_EN to build err_count.
module serial_rx_checker #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned LOCK_LOSS = 4
) (
  input  logic        t_clk,
  input  logic        rst,
  input  logic        serial_in,
  input  logic        clear,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        locked,
  output logic        err_flag,
  output logic [15:0] err_count
);

  typedef enum logic {HUNT, LOCK} state_t;

  localparam logic [3:0] LOSS_LIM = 4'(LOCK_LOSS);

  state_t     state;
  logic [7:0] sr;
  logic [7:0] exp_byte;
  logic [2:0] bit_cnt;
  logic [3:0] miss_cnt;
  logic [7:0] win;

  assign win = {sr[6:0], serial_in};

  // The shifter never stops, so hunting can resume on the very next cycle after clear.
  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) sr <= 8'h00;
    else     sr <= win;
  end

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      locked     <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      err_flag   <= 1'b0;
      exp_byte   <= 8'h00;
      bit_cnt    <= 3'd0;
      miss_cnt   <= 4'd0;
    end else begin
      data_valid <= 1'b0;
      err_flag   <= 1'b0;
      if (clear) begin
        state    <= HUNT;
        locked   <= 1'b0;
        bit_cnt  <= 3'd0;
        miss_cnt <= 4'd0;
      end else begin
        case (state)
          HUNT: begin
            if (win == SYNC_WORD) begin
              state    <= LOCK;
              locked   <= 1'b1;
              bit_cnt  <= 3'd0;
              exp_byte <= 8'h00;
              miss_cnt <= 4'd0;
            end
          end
          LOCK: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_out   <= win;
              data_valid <= 1'b1;
              if (win == exp_byte) begin
                exp_byte <= exp_byte + 8'd1;
                miss_cnt <= 4'd0;
              end else begin
                // Re-seed from the received byte so one corrupt byte costs one error.
                err_flag <= 1'b1;
                exp_byte <= win + 8'd1;
                miss_cnt <= miss_cnt + 4'd1;
                if (miss_cnt + 4'd1 == LOSS_LIM) begin
                  state  <= HUNT;
                  locked <= 1'b0;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef SERIAL_RX_ERR_CNT_EN
  logic byte_bad;
  assign byte_bad = (state == LOCK) && (bit_cnt == 3'd7) && (win != exp_byte);

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst)                                  err_count <= 16'h0000;
    else if (clear)                           err_count <= 16'h0000;
    else if (byte_bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_serial_rx_checker.sv
// Scoreboard bench for serial_rx_checker: expected bytes are queued as they are
// sent and popped whenever data_valid pulses.
module tb_serial_rx_checker;

  logic        t_clk;
  logic        rst;
  logic        serial_in;
  logic        clear;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        locked;
  logic        err_flag;
  logic [15:0] err_count;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dv_seen = 0;
  int   err_seen = 0;

  serial_rx_checker #(.SYNC_WORD(8'hA5), .LOCK_LOSS(4)) dut (
    .t_clk(t_clk), .rst(rst), .serial_in(serial_in), .clear(clear),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .err_flag(err_flag), .err_count(err_count)
  );

  initial begin
    t_clk = 1'b0;
    forever #5 t_clk = ~t_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Output monitor
  always @(negedge t_clk) begin
    if (!rst) begin
      if (err_flag && !data_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL err_without_valid: err_flag=1 data_valid=0 at %0t", $time);
      end
      if (data_valid) begin
        exp_t e;
        dv_seen++;
        if (err_flag) err_seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: data_out=%h err_flag=%b, none expected", data_out, err_flag);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.data || err_flag !== e.err) begin
            n_bad++;
            $display("FAIL byte: got %h/err=%b, want %h/err=%b", data_out, err_flag, e.data, e.err);
          end
        end
      end
    end
  end

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef SERIAL_RX_ERR_CNT_EN
    return 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge t_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    exp_q.push_back({d, e});
  endtask

  task automatic do_reset();
    rst = 1'b1; serial_in = 1'b0; clear = 1'b0;
    repeat (3) @(posedge t_clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drained: %0d bytes still expected, want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    int dv0;
    n_cmp++;
    if ({data_out, data_valid, locked, err_flag, err_count} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_state: out=%h dv=%b lk=%b ef=%b cnt=%h, want all 0",
               data_out, data_valid, locked, err_flag, err_count);
    end
    repeat (2) @(posedge t_clk);
    #1 rst = 1'b0;
    send_byte(8'hA5);
    push(8'h37, 1'b1);
    send_byte(8'h37);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({data_out, data_valid, locked, err_flag, err_count} !== 27'd0) begin
      n_bad++;
      $display("FAIL midstream_reset: out=%h dv=%b lk=%b ef=%b cnt=%h, want all 0",
               data_out, data_valid, locked, err_flag, err_count);
    end
    repeat (3) @(posedge t_clk);
    #1 rst = 1'b0; serial_in = 1'b0;
    dv0 = dv_seen;
    repeat (20) send_bit(1'b0);
    n_cmp++;
    if (locked !== 1'b0 || dv_seen != dv0) begin
      n_bad++;
      $display("FAIL idle_after_reset: locked=%b valids=%0d, want 0/0", locked, dv_seen - dv0);
    end
    check_drained("reset");
  endtask

  task automatic test_basic();
    logic [7:0] s;
    int dv0, er0;
    do_reset();
    dv0 = dv_seen; er0 = err_seen;
    s = 8'hA5;
    repeat (3) send_bit(1'b0);
    for (int i = 7; i >= 1; i--) send_bit(s[i]);
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++; $display("FAIL early_lock: locked=%b, want 0", locked);
    end
    send_bit(s[0]);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL lock_edge: locked=%b, want 1", locked);
    end
    push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'h02, 1'b0);
    send_byte(8'h00);
    n_cmp++;
    if (data_valid !== 1'b1 || data_out !== 8'h00) begin
      n_bad++; $display("FAIL first_latency: dv=%b out=%h, want 1/00", data_valid, data_out);
    end
    send_byte(8'h01);
    send_byte(8'h02);
    send_bit(1'b0);
    n_cmp++;
    if (dv_seen - dv0 != 3 || err_seen != er0 || err_count !== 16'h0) begin
      n_bad++;
      $display("FAIL basic_counts: valids=%0d errs=%0d cnt=%h, want 3/0/0000",
               dv_seen - dv0, err_seen - er0, err_count);
    end
    check_drained("basic");
  endtask

  task automatic test_wrap();
    int dv0, er0;
    do_reset();
    dv0 = dv_seen; er0 = err_seen;
    send_byte(8'hA5);
    for (int i = 0; i < 256; i++) begin
      push(8'(i), 1'b0);
      send_byte(8'(i));
    end
    push(8'h00, 1'b0);
    send_byte(8'h00);
    send_bit(1'b0);
    n_cmp++;
    if (dv_seen - dv0 != 257 || err_seen != er0 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap: valids=%0d errs=%0d locked=%b, want 257/0/1",
               dv_seen - dv0, err_seen - er0, locked);
    end
    check_drained("wrap");
  endtask

  task automatic test_single_err();
    int er0;
    do_reset();
    er0 = err_seen;
    send_byte(8'hA5);
    push(8'h00, 1'b0); send_byte(8'h00);
    push(8'h01, 1'b0); send_byte(8'h01);
    push(8'h07, 1'b1); send_byte(8'h07);
    push(8'h08, 1'b0); send_byte(8'h08);
    push(8'h09, 1'b0); send_byte(8'h09);
    send_bit(1'b0);
    n_cmp++;
    if (err_seen - er0 != 1 || err_count !== exp_cnt(1) || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_err: errs=%0d cnt=%h locked=%b, want 1/%h/1",
               err_seen - er0, err_count, locked, exp_cnt(1));
    end
    check_drained("single_err");
  endtask

  task automatic test_lock_loss();
    int er0;
    do_reset();
    er0 = err_seen;
    send_byte(8'hA5);
    push(8'h00, 1'b0); send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      push(8'h05, 1'b1); send_byte(8'h05);
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL lock_hold_3miss: locked=%b, want 1", locked);
    end
    push(8'h05, 1'b1); send_byte(8'h05);
    n_cmp++;
    if (locked !== 1'b0 || data_valid !== 1'b1 || err_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_drop: locked=%b dv=%b ef=%b, want 0/1/1", locked, data_valid, err_flag);
    end
    send_byte(8'hA5);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL relock: locked=%b, want 1", locked);
    end
    push(8'h00, 1'b0); send_byte(8'h00);
    send_bit(1'b0);
    n_cmp++;
    if (err_seen - er0 != 4 || err_count !== exp_cnt(4)) begin
      n_bad++;
      $display("FAIL loss_counts: errs=%0d cnt=%h, want 4/%h", err_seen - er0, err_count, exp_cnt(4));
    end
    check_drained("lock_loss");
  endtask

  task automatic test_clear();
    logic [7:0] p;
    int er0;
    do_reset();
    er0 = err_seen;
    send_byte(8'hA5);
    push(8'h00, 1'b0); send_byte(8'h00);
    push(8'h10, 1'b1); send_byte(8'h10);
    push(8'h20, 1'b1); send_byte(8'h20);
    push(8'h30, 1'b1); send_byte(8'h30);
    p = 8'h31;
    for (int i = 7; i >= 4; i--) send_bit(p[i]);
    n_cmp++;
    if (err_count !== exp_cnt(3) || locked !== 1'b1 || err_seen - er0 != 3) begin
      n_bad++;
      $display("FAIL pre_clear: cnt=%h locked=%b errs=%0d, want %h/1/3",
               err_count, locked, err_seen - er0, exp_cnt(3));
    end
    clear = 1'b1; serial_in = 1'b0;
    @(posedge t_clk); #1;
    clear = 1'b0;
    n_cmp++;
    if (err_count !== 16'h0 || locked !== 1'b0 || data_valid !== 1'b0 || err_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL clear: cnt=%h locked=%b dv=%b ef=%b, want 0000/0/0/0",
               err_count, locked, data_valid, err_flag);
    end
    repeat (8) send_bit(1'b0);
    send_byte(8'hA5);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL clear_relock: locked=%b, want 1", locked);
    end
    push(8'h00, 1'b0); send_byte(8'h00);
    send_bit(1'b0);
    n_cmp++;
    if (err_count !== 16'h0 || err_seen - er0 != 3) begin
      n_bad++;
      $display("FAIL post_clear: cnt=%h errs=%0d, want 0000/3", err_count, err_seen - er0);
    end
    check_drained("clear");
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b0; clear = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_single_err();
    test_lock_loss();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_rx_checker.md
# serial_rx_checker

Receive-side partner of the self-test serializer: takes the MSB-first serial bit stream, finds byte alignment by hunting for a sync word, and deserializes it into bytes. Once locked, it checks each recovered byte against an incrementing test pattern and reports mismatches. It sits directly downstream of the serializer, at the far end of the link under test, on the same `t_clk` domain.

## Interface
Parameters:
- `SYNC_WORD`, 8'hA5, alignment byte hunted for in the serial stream.
- `LOCK_LOSS`, 4, consecutive payload mismatches that drop lock (legal range 1..15).

Ports:
- `t_clk`  in  1  bit clock; one serial bit is sampled per rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `serial_in`  in  1  serial data, MSB of each byte first.
- `clear`  in  1  synchronous clear: returns to HUNT and zeroes counters.
- `data_out`  out  8  last recovered byte.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `locked`  out  1  high while in LOCK.
- `err_flag`  out  1  one-cycle pulse on a payload mismatch.
- `err_count`  out  16  total mismatches, saturating.

## Operation
- `sr[7:0]` shifts every cycle: `sr <= {sr[6:0], serial_in}`. The window is `win = {sr[6:0], serial_in}`.
- State machine with two states, HUNT and LOCK. Reset state is HUNT.
- **HUNT**
  - Every cycle, compare `win` against `SYNC_WORD`.
  - On a match, go to LOCK: `bit_cnt <= 0`, `exp <= 8'h00`, `miss_cnt <= 0`.
  - No `data_valid` or `err_flag` in HUNT.
- **LOCK**
  - `bit_cnt` (3 bits) increments every cycle and wraps 7→0.
  - On the edge where `bit_cnt == 7`, one byte is complete. Then `data_out <= win` and `data_valid <= 1`.
  - If `win == exp`: `exp <= exp + 1` (mod 256) and `miss_cnt <= 0`.
  - Otherwise:
    - `err_flag <= 1` and `err_count` increments, saturating at 16'hFFFF.
    - `exp <= win + 1`, which re-seeds the pattern so a single bad byte costs one error.
    - `miss_cnt` increments. If it reaches `LOCK_LOSS`, go to HUNT with `locked <= 0`. `data_valid`/`err_flag` for that byte still pulse.
- A `SYNC_WORD` value seen while in LOCK is treated as ordinary payload.
- False lock on payload that aliases `SYNC_WORD` is permitted. It is recovered by the `LOCK_LOSS` mechanism.
- `clear` sets state HUNT and zeroes `err_count`, `miss_cnt`, `bit_cnt`, `data_valid`, `err_flag` and `locked`.
  - `clear` beats a byte completion or sync match in the same cycle.
  - `sr` keeps shifting during `clear`.
- `rst` beats everything. It may occur mid-byte or mid-lock and takes effect immediately.

## Timing
- Reset values: `data_out` = 8'h00, `data_valid` = 0, `locked` = 0, `err_flag` = 0, `err_count` = 0. Internal `sr`, `exp`, `bit_cnt` and `miss_cnt` are also 0.
- All outputs are registered.
- `locked` rises on the edge that samples the last (LSB) bit of the sync word.
- The first payload `data_valid` comes 8 edges after `locked` rises. Subsequent pulses come every 8 edges.
- Latency: the LSB of a byte is sampled and the byte is presented on `data_out` at the same edge. `data_valid` is high for the following cycle only.
- `err_flag` is coincident with `data_valid` of the offending byte.
- `locked` falls on the same edge as the `LOCK_LOSS`-th mismatch's `data_valid`.

## Configuration
- `SERIAL_RX_ERR_CNT_EN` defined: the 16-bit saturating `err_count` register is built.
- Undefined: `err_count` is tied to 16'h0000 and no counter logic is built. `err_flag`, the lock logic and `miss_cnt` are unchanged.

## Test plan
- Reset → assert `rst` for 3 cycles mid-stream → all outputs 0 and state HUNT. Release with `serial_in` = 0 → `locked` stays 0 and no `data_valid`.
- 3 idle 0 bits, then 8'hA5, 8'h00, 8'h01, 8'h02 → `locked` rises on the A5 LSB edge. Three `data_valid` pulses 8 cycles apart carry 00, 01, 02. `err_count` = 0.
- After sync, send 8'h00..8'hFF, then 8'h00 → 257 valid bytes, zero `err_flag` across the wrap, `locked` stays 1.
- After sync, send 00, 01, 07, 08, 09 → exactly one `err_flag`, on 07. `err_count` = 1, `locked` stays 1.
- After sync, send 00, 05, 05, 05, 05 → four `err_flag` pulses; `locked` drops on the fourth. Then send A5, 00 → relock with no new error.
- Locked stream; assert `clear` for 1 cycle mid-byte with `err_count` = 3 → `err_count` = 0 and `locked` = 0 next cycle. Resend A5 → relock. Repeat with `SERIAL_RX_ERR_CNT_EN` undefined → `err_count` always 0, `err_flag` pulses unchanged.
